dmi_reg_responder: RTL and testbench

- Debug-module-side responder for the DMI request/response interface.
- Accepts one dm::dmi_req_t at a time on clk_i, range-checks the address and performs the access on a simple req/gnt/rvalid register bus toward the DM CSR file.
- Returns exactly one dm::dmi_resp_t per accepted request, including NOPs.
- Sits between the core-side outputs of the DMI CDC and the DM register logic.

---
 rtl/dmi_reg_responder.sv | 186 ++++++++++++++++++
 tb/tb_dmi_reg_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_reg_responder.sv
// DMI request/response responder: range-checks DMI requests and performs them on a
// req/gnt/rvalid register bus. Optional backend watchdog enabled by DMI_TIMEOUT_EN.
module dmi_reg_responder #(
   parameter logic [6:0]  AddrLo        = 7'h04,
   parameter logic [6:0]  AddrHi        = 7'h7F,
   parameter int unsigned TimeoutCycles = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [40:0] dmi_req_i,
   input  logic        dmi_req_valid_i,
   output logic        dmi_req_ready_o,
   output logic [33:0] dmi_resp_o,
   output logic        dmi_resp_valid_o,
   input  logic        dmi_resp_ready_i,
   output logic        reg_req_o,
   output logic        reg_we_o,
   output logic [6:0]  reg_addr_o,
   output logic [31:0] reg_wdata_o,
   input  logic        reg_gnt_i,
   input  logic        reg_rvalid_i,
   input  logic [31:0] reg_rdata_i,
   input  logic        reg_err_i
);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StAccess  = 2'd1;
   localparam logic [1:0] StWait    = 2'd2;
   localparam logic [1:0] StRespond = 2'd3;

   localparam logic [1:0] OpNop   = 2'd0;
   localparam logic [1:0] OpRead  = 2'd1;
   localparam logic [1:0] OpWrite = 2'd2;

   localparam logic [1:0] RespOk   = 2'd0;
   localparam logic [1:0] RespFail = 2'd2;

   if (TimeoutCycles < 2 || TimeoutCycles > 255) begin : g_bad_timeout
      $error("dmi_reg_responder: TimeoutCycles must be in 2..255");
   end

   logic [1:0]  state_q,    state_d;
   logic        ready_q,    ready_d;
   logic [6:0]  addr_q,     addr_d;
   logic [1:0]  op_q,       op_d;
   logic [31:0] wdata_q,    wdata_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic [1:0]  rsp_code_q, rsp_code_d;

   logic [6:0]  req_addr;
   logic [1:0]  req_op;
   logic [31:0] req_data;
   logic        req_in_range;
   logic        req_is_bus;

   assign req_addr = dmi_req_i[40:34];
   assign req_op   = dmi_req_i[33:32];
   assign req_data = dmi_req_i[31:0];

   // Widened compare keeps the range check meaningful for any AddrHi up to 7'h7F.
   assign req_in_range = ({1'b0, req_addr} >= {1'b0, AddrLo}) &&
                         ({1'b0, req_addr} <= {1'b0, AddrHi});
   assign req_is_bus   = (req_op == OpRead || req_op == OpWrite) && req_in_range;

`ifdef DMI_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   logic       drain_q, drain_d;
   logic       timeout_hit;

   assign timeout_hit = ((cnt_q + 8'd1) == 8'(TimeoutCycles));
`endif

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      op_d       = op_q;
      wdata_d    = wdata_q;
      rsp_data_d = rsp_data_q;
      rsp_code_d = rsp_code_q;
`ifdef DMI_TIMEOUT_EN
      cnt_d      = cnt_q;
      // A late completion of an abandoned transaction is swallowed here.
      drain_d    = drain_q && !reg_rvalid_i;
`endif

      case (state_q)
         StIdle: begin
            if (dmi_req_valid_i && ready_q) begin
               addr_d  = req_addr;
               op_d    = req_op;
               wdata_d = req_data;
               if (req_is_bus) begin
                  state_d = StAccess;
`ifdef DMI_TIMEOUT_EN
                  cnt_d   = 8'd0;
`endif
               end else begin
                  state_d    = StRespond;
                  rsp_data_d = 32'd0;
                  rsp_code_d = (req_op == OpNop) ? RespOk : RespFail;
               end
            end
         end
         StAccess: begin
`ifdef DMI_TIMEOUT_EN
            cnt_d = cnt_q + 8'd1;
`endif
            if (reg_gnt_i) begin
               state_d = StWait;
`ifdef DMI_TIMEOUT_EN
            end else if (timeout_hit) begin
               state_d    = StRespond;
               rsp_data_d = 32'd0;
               rsp_code_d = RespFail;
`endif
            end
         end
         StWait: begin
`ifdef DMI_TIMEOUT_EN
            cnt_d = cnt_q + 8'd1;
`endif
            if (reg_rvalid_i) begin
               state_d    = StRespond;
               rsp_data_d = (op_q == OpRead) ? reg_rdata_i : wdata_q;
               rsp_code_d = reg_err_i ? RespFail : RespOk;
`ifdef DMI_TIMEOUT_EN
            end else if (timeout_hit) begin
               // Grant was given, so the bus still owes one rvalid.
               state_d    = StRespond;
               rsp_data_d = 32'd0;
               rsp_code_d = RespFail;
               drain_d    = 1'b1;
`endif
            end
         end
         default: begin
            if (dmi_resp_ready_i) begin
               state_d = StIdle;
            end
         end
      endcase

`ifdef DMI_TIMEOUT_EN
      ready_d = (state_d == StIdle) && !drain_d;
`else
      ready_d = (state_d == StIdle);
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         ready_q    <= 1'b0;
         addr_q     <= 7'd0;
         op_q       <= 2'd0;
         wdata_q    <= 32'd0;
         rsp_data_q <= 32'd0;
         rsp_code_q <= 2'd0;
`ifdef DMI_TIMEOUT_EN
         cnt_q      <= 8'd0;
         drain_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         addr_q     <= addr_d;
         op_q       <= op_d;
         wdata_q    <= wdata_d;
         rsp_data_q <= rsp_data_d;
         rsp_code_q <= rsp_code_d;
`ifdef DMI_TIMEOUT_EN
         cnt_q      <= cnt_d;
         drain_q    <= drain_d;
`endif
      end
   end

   assign dmi_req_ready_o  = ready_q;
   assign dmi_resp_valid_o = (state_q == StRespond);
   assign dmi_resp_o       = {rsp_data_q, rsp_code_q};
   assign reg_req_o        = (state_q == StAccess);
   assign reg_we_o         = (op_q == OpWrite);
   assign reg_addr_o       = addr_q;
   assign reg_wdata_o      = wdata_q;

endmodule

// File: tb/tb_dmi_reg_responder.sv
// Directed bench for dmi_reg_responder; timeout scenarios run when DMI_TIMEOUT_EN is defined.
module tb_dmi_reg_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [40:0] dmi_req = '0;
   logic        dmi_req_valid = 1'b0;
   logic        dmi_req_ready;
   logic [33:0] dmi_resp;
   logic        dmi_resp_valid;
   logic        dmi_resp_ready = 1'b0;
   logic        reg_req;
   logic        reg_we;
   logic [6:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic        reg_gnt = 1'b0;
   logic        reg_rvalid = 1'b0;
   logic [31:0] reg_rdata = '0;
   logic        reg_err = 1'b0;

   int checks = 0;
   int errors = 0;

   dmi_reg_responder #(
      .AddrLo(7'h04), .AddrHi(7'h7F), .TimeoutCycles(8)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .dmi_req_i(dmi_req), .dmi_req_valid_i(dmi_req_valid), .dmi_req_ready_o(dmi_req_ready),
      .dmi_resp_o(dmi_resp), .dmi_resp_valid_o(dmi_resp_valid), .dmi_resp_ready_i(dmi_resp_ready),
      .reg_req_o(reg_req), .reg_we_o(reg_we), .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata),
      .reg_gnt_i(reg_gnt), .reg_rvalid_i(reg_rvalid), .reg_rdata_i(reg_rdata), .reg_err_i(reg_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents one request and returns in the cycle after acceptance.
   task automatic send(input logic [6:0] addr, input logic [1:0] op, input logic [31:0] data);
      for (int i = 0; i < 20 && !dmi_req_ready; i++) step();
      chk("req_ready_before_send", 64'(dmi_req_ready), 64'd1);
      dmi_req = {addr, op, data};
      dmi_req_valid = 1'b1;
      step();
      dmi_req_valid = 1'b0;
   endtask

   task automatic handshake();
      dmi_resp_ready = 1'b1;
      step();
      dmi_resp_ready = 1'b0;
      chk("resp_valid_after_hs", 64'(dmi_resp_valid), 64'd0);
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_ready", 64'(dmi_req_ready), 64'd0);
      chk("rst_resp_valid", 64'(dmi_resp_valid), 64'd0);
      chk("rst_resp", 64'(dmi_resp), 64'd0);
      chk("rst_reg_req", 64'(reg_req), 64'd0);
      chk("rst_reg_we", 64'(reg_we), 64'd0);
      chk("rst_reg_addr", 64'(reg_addr), 64'd0);
      chk("rst_reg_wdata", 64'(reg_wdata), 64'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("ready_after_rst", 64'(dmi_req_ready), 64'd1);

      // NOP: response one cycle after acceptance, no bus access
      send(7'h10, 2'd0, 32'h0);
      chk("nop_resp_valid", 64'(dmi_resp_valid), 64'd1);
      chk("nop_resp", 64'(dmi_resp), 64'd0);
      chk("nop_reg_req", 64'(reg_req), 64'd0);
      chk("nop_ready", 64'(dmi_req_ready), 64'd0);
      handshake();
      chk("nop_ready_back", 64'(dmi_req_ready), 64'd1);

      // WRITE with zero-wait bus
      send(7'h10, 2'd2, 32'hDEADBEEF);
      chk("wr_reg_req", 64'(reg_req), 64'd1);
      chk("wr_reg_we", 64'(reg_we), 64'd1);
      chk("wr_reg_addr", 64'(reg_addr), 64'h10);
      chk("wr_reg_wdata", 64'(reg_wdata), 64'hDEADBEEF);
      chk("wr_resp_valid_c1", 64'(dmi_resp_valid), 64'd0);
      reg_gnt = 1'b1;
      step();
      reg_gnt = 1'b0;
      chk("wr_reg_req_dropped", 64'(reg_req), 64'd0);
      chk("wr_resp_valid_c2", 64'(dmi_resp_valid), 64'd0);
      reg_rvalid = 1'b1; reg_rdata = 32'h0; reg_err = 1'b0;
      step();
      reg_rvalid = 1'b0;
      chk("wr_resp_valid_c3", 64'(dmi_resp_valid), 64'd1);
      chk("wr_resp", 64'(dmi_resp), {30'd0, 32'hDEADBEEF, 2'd0});
      handshake();

      // READ with 3 grant wait cycles and a bus error
      send(7'h11, 2'd1, 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk("rd_reg_req_wait", 64'(reg_req), 64'd1);
         chk("rd_ready_wait", 64'(dmi_req_ready), 64'd0);
         chk("rd_we_wait", 64'(reg_we), 64'd0);
         step();
      end
      reg_gnt = 1'b1;
      step();
      reg_gnt = 1'b0;
      chk("rd_ready_waitrv", 64'(dmi_req_ready), 64'd0);
      reg_rvalid = 1'b1; reg_rdata = 32'h12345678; reg_err = 1'b1;
      step();
      reg_rvalid = 1'b0; reg_err = 1'b0;
      chk("rd_resp_valid", 64'(dmi_resp_valid), 64'd1);
      chk("rd_resp", 64'(dmi_resp), {30'd0, 32'h12345678, 2'd2});
      chk("rd_ready_resp", 64'(dmi_req_ready), 64'd0);
      handshake();

      // Out-of-range address and reserved op
      send(7'h02, 2'd1, 32'h0);
      chk("oor_resp_valid", 64'(dmi_resp_valid), 64'd1);
      chk("oor_resp", 64'(dmi_resp), 64'd2);
      chk("oor_reg_req", 64'(reg_req), 64'd0);
      handshake();
      send(7'h10, 2'd3, 32'hFFFF0000);
      chk("op3_resp_valid", 64'(dmi_resp_valid), 64'd1);
      chk("op3_resp", 64'(dmi_resp), 64'd2);
      chk("op3_reg_req", 64'(reg_req), 64'd0);
      handshake();

      // Lowest forwarded address goes to the bus
      send(7'h04, 2'd1, 32'h0);
      chk("lo_reg_req", 64'(reg_req), 64'd1);
      chk("lo_reg_addr", 64'(reg_addr), 64'h04);
      reg_gnt = 1'b1;
      step();
      reg_gnt = 1'b0;
      reg_rvalid = 1'b1; reg_rdata = 32'hAAAA5555;
      step();
      reg_rvalid = 1'b0;
      chk("lo_resp", 64'(dmi_resp), {30'd0, 32'hAAAA5555, 2'd0});
      handshake();

      // Response backpressure, then back-to-back acceptance
      send(7'h20, 2'd1, 32'h0);
      reg_gnt = 1'b1;
      step();
      reg_gnt = 1'b0;
      reg_rvalid = 1'b1; reg_rdata = 32'h0BADF00D;
      step();
      reg_rvalid = 1'b0; reg_rdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_resp_valid", 64'(dmi_resp_valid), 64'd1);
         chk("bp_resp_stable", 64'(dmi_resp), {30'd0, 32'h0BADF00D, 2'd0});
         chk("bp_ready", 64'(dmi_req_ready), 64'd0);
         step();
      end
      handshake();
      chk("b2b_ready", 64'(dmi_req_ready), 64'd1);
      dmi_req = {7'h30, 2'd0, 32'h0};
      dmi_req_valid = 1'b1;
      step();
      dmi_req_valid = 1'b0;
      chk("b2b_resp_valid", 64'(dmi_resp_valid), 64'd1);
      chk("b2b_resp", 64'(dmi_resp), 64'd0);
      handshake();

`ifdef DMI_TIMEOUT_EN
      // No grant: 8 cycles in Access, then failed response
      send(7'h10, 2'd1, 32'h0);
      for (int i = 0; i < 7; i++) begin
         chk("to_access_req", 64'(reg_req), 64'd1);
         step();
      end
      chk("to_access_req_last", 64'(reg_req), 64'd1);
      chk("to_access_no_resp", 64'(dmi_resp_valid), 64'd0);
      step();
      chk("to_access_resp_valid", 64'(dmi_resp_valid), 64'd1);
      chk("to_access_resp", 64'(dmi_resp), 64'd2);
      chk("to_access_req_drop", 64'(reg_req), 64'd0);
      handshake();
      chk("to_access_ready", 64'(dmi_req_ready), 64'd1);

      // Grant given, rvalid late: drain blocks new requests
      send(7'h10, 2'd1, 32'h0);
      reg_gnt = 1'b1;
      step();
      reg_gnt = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("to_wait_no_resp", 64'(dmi_resp_valid), 64'd0);
      step();
      chk("to_wait_resp_valid", 64'(dmi_resp_valid), 64'd1);
      chk("to_wait_resp", 64'(dmi_resp), 64'd2);
      handshake();
      for (int i = 0; i < 3; i++) begin
         chk("drain_ready", 64'(dmi_req_ready), 64'd0);
         step();
      end
      reg_rvalid = 1'b1; reg_rdata = 32'h77777777;
      step();
      reg_rvalid = 1'b0;
      chk("drain_cleared_ready", 64'(dmi_req_ready), 64'd1);
      chk("drain_no_resp", 64'(dmi_resp_valid), 64'd0);
`endif

      // Asynchronous reset in the middle of Access
      send(7'h10, 2'd2, 32'h00000055);
      chk("mid_reg_req", 64'(reg_req), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_reg_req", 64'(reg_req), 64'd0);
      chk("mid_rst_reg_we", 64'(reg_we), 64'd0);
      chk("mid_rst_reg_addr", 64'(reg_addr), 64'd0);
      chk("mid_rst_reg_wdata", 64'(reg_wdata), 64'd0);
      chk("mid_rst_ready", 64'(dmi_req_ready), 64'd0);
      chk("mid_rst_resp_valid", 64'(dmi_resp_valid), 64'd0);
      chk("mid_rst_resp", 64'(dmi_resp), 64'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_ready", 64'(dmi_req_ready), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
